// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the receive and transmit paths.
//   uart_state_t  - receiver FSM states (PARITY only with UART_RX_PARITY_EN)
//   uart_baud_div - clock cycles per bit, integer-truncated
package uart_pkg;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} uart_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} uart_state_t;
`endif

    function automatic int uart_baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: circular FIFO with show-ahead head word and arbitrary depth.
//   clk, reset    - clock, synchronous active-high reset
//   push, din     - write din when not full (or when popping in the same cycle)
//   pop           - drop head word; ignored while empty
//   head          - current head word, zero while empty
//   full, empty   - occupancy flags
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: UART receiver (LSB first, one stop bit) feeding a show-ahead FIFO.
//   clk, reset    - clock, synchronous active-high reset
//   rx_serial     - asynchronous serial line, idle high
//   read_enable   - pop head word while data_valid
//   output_data   - FIFO head word (zero while empty)
//   data_valid    - FIFO not empty
//   fifo_full     - FIFO holds MAX_ELEMENTS words
//   frame_error   - one-cycle pulse: bad stop bit (or bad parity)
//   overflow      - one-cycle pulse: good word dropped, FIFO full
// Build option: define UART_RX_PARITY_EN for an even-parity bit after the data bits.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int DATA_BITS     = 7,
    parameter int MAX_ELEMENTS  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_serial,
    input  logic                 read_enable,
    output logic [DATA_BITS-1:0] output_data,
    output logic                 data_valid,
    output logic                 fifo_full,
    output logic                 frame_error,
    output logic                 overflow
);
    localparam int DIV  = uart_baud_div(CLK_FREQUENCY, BAUD_RATE);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int BW   = $clog2(DATA_BITS + 1);

    uart_state_t          state, state_n;
    logic                 rx_meta, rx_sync;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic [DATA_BITS-1:0] word, word_n;
    logic                 push, fe_n, ov_n, tick, full, empty;
`ifdef UART_RX_PARITY_EN
    logic                 par_err, par_n;
`endif

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(MAX_ELEMENTS)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (read_enable),
        .din   (word),
        .head  (output_data),
        .full  (full),
        .empty (empty)
    );

    assign data_valid = !empty;
    assign fifo_full  = full;
    // cnt counts cycles since the previous sample; the start sample lands mid-bit.
    assign tick = cnt == CW'((state == START ? HALF : DIV) - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            word        <= '0;
            frame_error <= 1'b0;
            overflow    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err     <= 1'b0;
`endif
        end else begin
            rx_meta     <= rx_serial;
            rx_sync     <= rx_meta;
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_n;
            word        <= word_n;
            frame_error <= fe_n;
            overflow    <= ov_n;
`ifdef UART_RX_PARITY_EN
            par_err     <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = tick ? '0 : cnt + CW'(1);
        bit_n   = bit_idx;
        word_n  = word;
        push    = 1'b0;
        fe_n    = 1'b0;
        ov_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n   = par_err;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                if (!rx_sync)
                    state_n = START;
            end
            START: begin
                if (tick)
                    state_n = rx_sync ? IDLE : DATA;
            end
            DATA: begin
                if (tick) begin
                    word_n = DATA_BITS'({rx_sync, word} >> 1);
                    bit_n  = bit_idx + BW'(1);
                    if (bit_idx == BW'(DATA_BITS - 1))
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_n   = rx_sync ^ (^word);
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_n = rx_sync ? IDLE : WAIT_IDLE;
                    if (!rx_sync)
                        fe_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                    else if (par_err)
                        fe_n = 1'b1;
`endif
                    else if (full && !read_enable)
                        ov_n = 1'b1;
                    else
                        push = 1'b1;
                end
            end
            WAIT_IDLE: begin
                // Stay here through a break so a held-low line is not taken as a new start.
                cnt_n = '0;
                if (rx_sync)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
